// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: streams a program into imem and data into dmem, runs the cpu
// for a latched cycle count, then streams dmem back out.
module cpu_boot_ctrl #(
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] dmem_words,
  input  logic [31:0]      run_cycles,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             cpu_enable,
  output logic             out_valid,
  output logic [63:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam int WW = $clog2(RD_LAT + 2);
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] imem_q, imem_d, dmem_q, dmem_d, cnt_q, cnt_d;
  logic [31:0]      run_q, run_d, run_cnt_q, run_cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [63:0]      addr_i_q, addr_i_d, addr_d_q, addr_d_d, wdata_d_q, wdata_d_d, out_data_q, out_data_d;
  logic [31:0]      wdata_i_q, wdata_i_d;
  logic             wen_i_q, wen_i_d, wen_d_q, wen_d_d, ren_d_q, ren_d_d, en_q, en_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  // Zero counts skip their phase entirely, so a phase never opens in_ready for nothing.
  function automatic state_t after_run(input logic [CNT_W-1:0] d);
    return d != '0 ? DUMP_RD : DONE;
  endfunction
  function automatic state_t after_load_d(input logic [CNT_W-1:0] d, input logic [31:0] r);
    return r != '0 ? RUN : after_run(d);
  endfunction
  function automatic state_t after_load_i(input logic [CNT_W-1:0] d, input logic [31:0] r);
    return d != '0 ? LOAD_D : after_load_d(d, r);
  endfunction
  assign in_ready    = state_q == LOAD_I || state_q == LOAD_D;
  assign addr_ext    = addr_i_q;
  assign wen_ext     = wen_i_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_i_q;
  assign addr_ext_2  = addr_d_q;
  assign wen_ext_2   = wen_d_q;
  assign ren_ext_2   = ren_d_q;
  assign wdata_ext_2 = wdata_d_q;
  assign cpu_enable  = en_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  always_comb begin
    state_d     = state_q;
    imem_d      = imem_q;
    dmem_d      = dmem_q;
    run_d       = run_q;
    cnt_d       = cnt_q;
    run_cnt_d   = run_cnt_q;
    wait_d      = wait_q;
    addr_i_d    = addr_i_q;
    wdata_i_d   = wdata_i_q;
    addr_d_d    = addr_d_q;
    wdata_d_d   = wdata_d_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wen_i_d     = 1'b0;
    wen_d_d     = 1'b0;
    ren_d_d     = 1'b0;
    en_d        = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        imem_d    = imem_words;
        dmem_d    = dmem_words;
        run_d     = run_cycles;
        cnt_d     = '0;
        run_cnt_d = '0;
        state_d   = imem_words != '0 ? LOAD_I : after_load_i(dmem_words, run_cycles);
      end
      LOAD_I: if (in_valid) begin
        wen_i_d   = 1'b1;
        addr_i_d  = 64'(cnt_q) << 2;
        wdata_i_d = in_data[31:0];
        cnt_d     = cnt_q == imem_q - CNT_W'(1) ? '0 : cnt_q + CNT_W'(1);
        state_d   = cnt_q == imem_q - CNT_W'(1) ? after_load_i(dmem_q, run_q) : LOAD_I;
      end
      LOAD_D: if (in_valid) begin
        wen_d_d   = 1'b1;
        addr_d_d  = 64'(cnt_q) << 3;
        wdata_d_d = in_data;
        cnt_d     = cnt_q == dmem_q - CNT_W'(1) ? '0 : cnt_q + CNT_W'(1);
        state_d   = cnt_q == dmem_q - CNT_W'(1) ? after_load_d(dmem_q, run_q) : LOAD_D;
      end
      // The first RUN cycle is left idle so it never overlaps the last load write.
      RUN: begin
        en_d      = run_cnt_q != run_q;
        run_cnt_d = run_cnt_q != run_q ? run_cnt_q + 32'd1 : run_cnt_q;
        state_d   = run_cnt_q != run_q ? RUN : after_run(dmem_q);
      end
      DUMP_RD: begin
        ren_d_d  = 1'b1;
        addr_d_d = 64'(cnt_q) << 3;
        wait_d   = '0;
        state_d  = DUMP_WAIT;
      end
      DUMP_WAIT: if (wait_q == WW'(RD_LAT)) begin
        out_data_d  = rdata_ext_2;
        out_valid_d = 1'b1;
        state_d     = DUMP_OUT;
      end else wait_d = wait_q + WW'(1);
      DUMP_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = cnt_q == dmem_q - CNT_W'(1) ? DONE : DUMP_RD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d == IDLE || state_d == DONE);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      imem_q      <= '0;
      dmem_q      <= '0;
      run_q       <= '0;
      cnt_q       <= '0;
      run_cnt_q   <= '0;
      wait_q      <= '0;
      addr_i_q    <= '0;
      wdata_i_q   <= '0;
      addr_d_q    <= '0;
      wdata_d_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wen_i_q     <= 1'b0;
      wen_d_q     <= 1'b0;
      ren_d_q     <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_q      <= imem_d;
      dmem_q      <= dmem_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      run_cnt_q   <= run_cnt_d;
      wait_q      <= wait_d;
      addr_i_q    <= addr_i_d;
      wdata_i_q   <= wdata_i_d;
      addr_d_q    <= addr_d_d;
      wdata_d_q   <= wdata_d_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wen_i_q     <= wen_i_d;
      wen_d_q     <= wen_d_d;
      ren_d_q     <= ren_d_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl: directed scenarios for the boot sequencer with a dmem model.
module tb_cpu_boot_ctrl;
  localparam int CNT_W = 10;
  localparam int LIMIT = 2000;
  logic clk = 0, arst_n = 1, start = 0;
  logic [CNT_W-1:0] imem_words = 0, dmem_words = 0;
  logic [31:0] run_cycles = 0;
  logic in_valid = 0, in_ready, out_ready = 0;
  logic [63:0] in_data = 0, rdata_ext_2 = 0;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, out_data;
  logic [31:0] wdata_ext;
  logic wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, out_valid, busy, done;
  int total = 0, bad = 0;
  logic [63:0] dmem [64];
  logic [63:0] words [$];
  logic [63:0] i_addr [$], i_data [$], d_addr [$], d_data [$], outs [$];
  int en_cnt = 0, en_bursts = 0, busy_seen = 0;
  logic prev_en = 0, prev_hold = 0;
  logic [63:0] prev_data = 0;

  cpu_boot_ctrl #(.CNT_W(CNT_W), .RD_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_words(imem_words), .dmem_words(dmem_words),
    .run_cycles(run_cycles), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[8:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[8:3]];
  end

  always @(negedge clk) begin
    total++;
    if ($countones({wen_ext, wen_ext_2, ren_ext_2, cpu_enable}) > 1) begin
      bad++;
      $display("FAIL onehot: wen=%b wen2=%b ren2=%b en=%b, required at most one high", wen_ext, wen_ext_2, ren_ext_2, cpu_enable);
    end
    total++;
    if (ren_ext !== 1'b0) begin bad++; $display("FAIL ren_ext: got %b, required 0", ren_ext); end
    if (wen_ext) begin i_addr.push_back(addr_ext); i_data.push_back({32'b0, wdata_ext}); end
    if (wen_ext_2) begin d_addr.push_back(addr_ext_2); d_data.push_back(wdata_ext_2); end
    if (cpu_enable) en_cnt++;
    if (cpu_enable && !prev_en) en_bursts++;
    prev_en = cpu_enable;
    if (busy) busy_seen++;
    if (prev_hold && out_valid) begin
      total++;
      if (out_data !== prev_data) begin bad++; $display("FAIL out_stable: got %h, required %h", out_data, prev_data); end
    end
    if (out_valid && out_ready) outs.push_back(out_data);
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
  end

  function automatic logic [296:0] all_outs();
    return {addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
            cpu_enable, out_valid, out_data, busy, done, in_ready};
  endfunction

  // Drives one start and feeds the load stream until done, a timeout, or an abort point.
  task automatic run_seq(input int ni, input int nd, input int nr, input bit gap, input bit stall,
                         input bit midstart, input int abort_at, output int cyc);
    int idx = 0, sc = 0, c = 0;
    bit fired = 0;
    i_addr.delete(); i_data.delete(); d_addr.delete(); d_data.delete(); outs.delete(); words.delete();
    en_cnt = 0; en_bursts = 0; busy_seen = 0; prev_hold = 0;
    for (int k = 0; k < ni + nd; k++) words.push_back({16'hC0DE, 16'(k), 16'(ni * 16 + nd), 16'(k * 37 + 5)});
    @(posedge clk); #2;
    imem_words = CNT_W'(ni); dmem_words = CNT_W'(nd); run_cycles = 32'(nr); start = 1;
    @(posedge clk); #2;
    start = 0; imem_words = '1; dmem_words = '1; run_cycles = '1;
    while (c < LIMIT) begin
      if ((abort_at == 1 && d_addr.size() >= 2) || (abort_at == 2 && en_cnt >= 3)) begin
        arst_n = 0; in_valid = 0; out_ready = 0; start = 0; cyc = c;
        return;
      end
      if (done) break;
      in_valid = idx < words.size() && (!gap || c[0]);
      in_data = in_valid ? words[idx] : 64'h0;
      out_ready = !stall || sc >= 4;
      start = midstart && en_cnt == 3 && !fired;
      if (start) begin fired = 1; imem_words = 5; run_cycles = 2; end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) sc = out_ready ? 0 : sc + 1;
      @(posedge clk); #2;
      c++;
    end
    start = 0; in_valid = 0; out_ready = 0; cyc = c;
    total++;
    if (c >= LIMIT) begin bad++; $display("FAIL timeout: cycles %0d, required below %0d", c, LIMIT); end
  endtask

  task automatic test_reset();
    #3 arst_n = 0;
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL reset_outs: got %h, required 0", all_outs()); end
    repeat (2) @(posedge clk);
    #2 arst_n = 1;
    @(negedge clk);
    total++;
    if ({busy, done, in_ready} !== 3'b000) begin bad++; $display("FAIL reset_idle: busy/done/in_ready=%b, required 000", {busy, done, in_ready}); end
  endtask

  task automatic test_zero();
    int cyc;
    run_seq(0, 0, 0, 0, 0, 0, 0, cyc);
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b1 || cyc != 0) begin bad++; $display("FAIL zero_done: done=%b cycles=%0d, required 1 and 0", done, cyc); end
    total++;
    if (busy_seen != 0) begin bad++; $display("FAIL zero_busy: busy cycles %0d, required 0", busy_seen); end
    total++;
    if (i_addr.size() + d_addr.size() + en_cnt + outs.size() != 0) begin
      bad++; $display("FAIL zero_pulses: wen=%0d wen2=%0d en=%0d out=%0d, required all 0", i_addr.size(), d_addr.size(), en_cnt, outs.size());
    end
  endtask

  task automatic test_basic();
    int cyc;
    run_seq(3, 2, 5, 0, 0, 0, 0, cyc);
    total++;
    if (i_addr.size() != 3 || d_addr.size() != 2) begin bad++; $display("FAIL basic_wen_count: imem %0d dmem %0d, required 3 2", i_addr.size(), d_addr.size()); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (i_addr[k] !== 64'(4 * k) || i_data[k] !== {32'b0, words[k][31:0]}) begin
        bad++; $display("FAIL basic_imem%0d: addr %h data %h, required %h %h", k, i_addr[k], i_data[k], 64'(4 * k), {32'b0, words[k][31:0]});
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_addr[k] !== 64'(8 * k) || d_data[k] !== words[3 + k]) begin
        bad++; $display("FAIL basic_dmem%0d: addr %h data %h, required %h %h", k, d_addr[k], d_data[k], 64'(8 * k), words[3 + k]);
      end
      total++;
      if (outs[k] !== words[3 + k]) begin bad++; $display("FAIL basic_dump%0d: got %h, required %h", k, outs[k], words[3 + k]); end
    end
    total++;
    if (en_cnt != 5 || en_bursts != 1) begin bad++; $display("FAIL basic_run: en cycles %0d bursts %0d, required 5 1", en_cnt, en_bursts); end
    total++;
    if (outs.size() != 2 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_end: outs %0d done %b busy %b, required 2 1 0", outs.size(), done, busy);
    end
  endtask

  task automatic test_gap();
    int cyc;
    run_seq(4, 3, 2, 1, 0, 0, 0, cyc);
    total++;
    if (i_addr.size() != 4 || d_addr.size() != 3) begin bad++; $display("FAIL gap_wen_count: imem %0d dmem %0d, required 4 3", i_addr.size(), d_addr.size()); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (i_addr[k] !== 64'(4 * k) || i_data[k] !== {32'b0, words[k][31:0]}) begin
        bad++; $display("FAIL gap_imem%0d: addr %h data %h, required %h %h", k, i_addr[k], i_data[k], 64'(4 * k), {32'b0, words[k][31:0]});
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (d_addr[k] !== 64'(8 * k) || d_data[k] !== words[4 + k] || outs[k] !== words[4 + k]) begin
        bad++; $display("FAIL gap_dmem%0d: addr %h data %h dump %h, required %h %h", k, d_addr[k], d_data[k], outs[k], 64'(8 * k), words[4 + k]);
      end
    end
    total++;
    if (en_cnt != 2) begin bad++; $display("FAIL gap_run: en cycles %0d, required 2", en_cnt); end
  endtask

  task automatic test_stall();
    int cyc;
    run_seq(1, 3, 1, 0, 1, 0, 0, cyc);
    total++;
    if (outs.size() != 3) begin bad++; $display("FAIL stall_count: outs %0d, required 3", outs.size()); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (outs[k] !== words[1 + k]) begin bad++; $display("FAIL stall_dump%0d: got %h, required %h", k, outs[k], words[1 + k]); end
    end
    total++;
    if (cyc < 15) begin bad++; $display("FAIL stall_len: cycles %0d, required at least 15", cyc); end
  endtask

  task automatic test_start_busy();
    int cyc;
    run_seq(0, 1, 8, 0, 0, 1, 0, cyc);
    total++;
    if (en_cnt != 8 || en_bursts != 1) begin bad++; $display("FAIL busy_start_run: en cycles %0d bursts %0d, required 8 1", en_cnt, en_bursts); end
    total++;
    if (i_addr.size() != 0 || d_addr.size() != 1 || outs.size() != 1) begin
      bad++; $display("FAIL busy_start_seq: imem %0d dmem %0d outs %0d, required 0 1 1", i_addr.size(), d_addr.size(), outs.size());
    end
    total++;
    if (outs[0] !== words[0] || done !== 1'b1) begin bad++; $display("FAIL busy_start_dump: got %h done %b, required %h 1", outs[0], done, words[0]); end
  endtask

  task automatic test_done_restart();
    int cyc;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL restart_pre: done %b, required 1", done); end
    run_seq(2, 1, 3, 0, 0, 0, 0, cyc);
    total++;
    if (i_addr.size() != 2 || en_cnt != 3 || outs.size() != 1) begin
      bad++; $display("FAIL restart_seq: imem %0d en %0d outs %0d, required 2 3 1", i_addr.size(), en_cnt, outs.size());
    end
    total++;
    if (outs[0] !== words[2] || done !== 1'b1) begin bad++; $display("FAIL restart_dump: got %h done %b, required %h 1", outs[0], done, words[2]); end
  endtask

  task automatic test_abort();
    int cyc, ds, ec;
    run_seq(2, 6, 4, 0, 0, 0, 1, cyc);
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL abort_load_outs: got %h, required 0", all_outs()); end
    ds = d_addr.size();
    repeat (3) @(negedge clk);
    total++;
    if (d_addr.size() != ds || ds != 2) begin bad++; $display("FAIL abort_load_writes: dmem writes %0d, required 2", d_addr.size()); end
    @(posedge clk); #2 arst_n = 1;
    run_seq(0, 0, 20, 0, 0, 0, 2, cyc);
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL abort_run_outs: got %h, required 0", all_outs()); end
    ec = en_cnt;
    repeat (3) @(negedge clk);
    total++;
    if (en_cnt != ec || ec != 3) begin bad++; $display("FAIL abort_run_en: en cycles %0d, required 3", en_cnt); end
    @(posedge clk); #2 arst_n = 1;
    run_seq(3, 2, 5, 0, 0, 0, 0, cyc);
    total++;
    if (i_addr.size() != 3 || d_addr.size() != 2 || en_cnt != 5 || outs.size() != 2 || done !== 1'b1) begin
      bad++; $display("FAIL abort_fresh: imem %0d dmem %0d en %0d outs %0d done %b, required 3 2 5 2 1", i_addr.size(), d_addr.size(), en_cnt, outs.size(), done);
    end
    total++;
    if (outs[0] !== words[3] || outs[1] !== words[4]) begin bad++; $display("FAIL abort_fresh_dump: got %h %h, required %h %h", outs[0], outs[1], words[3], words[4]); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_gap();
    test_stall();
    test_start_busy();
    test_done_restart();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
